store_issue: RTL

STORE_ISSUE -- requirements
Module: store_issue

---
 rtl/store_issue_if.sv | 30 +++
 rtl/store_issue.sv | 113 +++++++++++
 2 files changed

// File: rtl/store_issue_if.sv
// store_issue_if: MEM-stage store request and SRAM-like write bus between the pipeline and store_issue.
interface store_issue_if;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] instr;
    logic [31:0] addr;
    logic [31:0] rt_data;
    logic        flush;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic        st_done;
    logic        ades;
    logic [31:0] ades_badvaddr;
    modport master (
        output st_valid, instr, addr, rt_data, flush, data_addr_ok, data_data_ok,
        input  st_ready, data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
               st_done, ades, ades_badvaddr
    );
    modport slave (
        input  st_valid, instr, addr, rt_data, flush, data_addr_ok, data_data_ok,
        output st_ready, data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
               st_done, ades, ades_badvaddr
    );
endinterface

// File: rtl/store_issue.sv
// store_issue: issues SB/SH/SW stores as one SRAM-like write; STORE_ALIGN_CHECK_EN enables misaligned-store (ades) detection.
module store_issue (
    input logic        clk,
    input logic        rst,
    store_issue_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t      state_q, state_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        done_q, done_d, cancel_q, cancel_d;
    logic        is_sb, is_sh, is_sw, go, mis;
    logic [1:0]  size_f;
    logic [31:0] addr_f, wdata_f;
    logic [3:0]  wstrb_f;
    always_comb begin
        is_sb   = bus.instr[31:26] == 6'b101000;
        is_sh   = bus.instr[31:26] == 6'b101001;
        is_sw   = bus.instr[31:26] == 6'b101011;
        go      = bus.st_valid && (is_sb || is_sh || is_sw) && !bus.flush;
`ifdef STORE_ALIGN_CHECK_EN
        mis     = (is_sh && bus.addr[0]) || (is_sw && bus.addr[1:0] != 2'b00);
`else
        mis     = 1'b0;
`endif
        size_f  = is_sw ? 2'd2 : is_sh ? 2'd1 : 2'd0;
        wdata_f = is_sw ? bus.rt_data : is_sh ? {2{bus.rt_data[15:0]}} : {4{bus.rt_data[7:0]}};
        wstrb_f = is_sw ? 4'b1111 : is_sh ? (bus.addr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << bus.addr[1:0];
        // sub-word offset bits are dropped so the slave sees the naturally aligned address
        addr_f  = is_sw ? {bus.addr[31:2], 2'b00} : is_sh ? {bus.addr[31:1], 1'b0} : bus.addr;
    end
    always_comb begin
        state_d  = state_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        done_d   = 1'b0;
        cancel_d = cancel_q;
        case (state_q)
            IDLE: if (go && !mis) begin
                state_d  = REQ;
                cancel_d = 1'b0;
                size_d   = size_f;
                addr_d   = addr_f;
                wdata_d  = wdata_f;
                wstrb_d  = wstrb_f;
            end
            REQ: if (bus.data_addr_ok) begin
                state_d  = bus.data_data_ok ? IDLE : WAIT;
                done_d   = bus.data_data_ok && !bus.flush;
                cancel_d = bus.flush;
            end else if (bus.flush) begin
                state_d = IDLE;
            end
            // once the address is taken the write cannot be withdrawn; a flush only hides st_done
            WAIT: begin
                cancel_d = cancel_q || bus.flush;
                if (bus.data_data_ok) begin
                    state_d = IDLE;
                    done_d  = !(cancel_q || bus.flush);
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            size_q   <= 2'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            wstrb_q  <= 4'd0;
            done_q   <= 1'b0;
            cancel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            done_q   <= done_d;
            cancel_q <= cancel_d;
        end
    end
    assign bus.st_ready   = state_q == IDLE;
    assign bus.data_req   = state_q == REQ;
    assign bus.data_wr    = state_q == REQ;
    assign bus.data_size  = size_q;
    assign bus.data_addr  = addr_q;
    assign bus.data_wdata = wdata_q;
    assign bus.data_wstrb = wstrb_q;
    assign bus.st_done    = done_q;
`ifdef STORE_ALIGN_CHECK_EN
    logic        ades_q;
    logic [31:0] badv_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            ades_q <= 1'b0;
            badv_q <= 32'd0;
        end else begin
            ades_q <= state_q == IDLE && go && mis;
            badv_q <= (state_q == IDLE && go && mis) ? bus.addr : badv_q;
        end
    end
    assign bus.ades          = ades_q;
    assign bus.ades_badvaddr = badv_q;
`else
    assign bus.ades          = 1'b0;
    assign bus.ades_badvaddr = 32'd0;
`endif
endmodule
